// File: rtl/sdram_line_arb.sv
// sdram_line_arb: shares one 16-bit SDRAM port between ioctl byte writes
// (buffered in a small FIFO) and scanline prefetch reads into a ping-pong
// line buffer. Define ARB_STATS_EN to add the stat_wr/stat_rd/stat_drop counters.
module sdram_line_arb #(
  parameter int ADDR_W      = 23,
  parameter int LINE_WORDS  = 512,
  parameter int WFIFO_DEPTH = 4,
  parameter int STARVE_MAX  = 8
) (
  input  logic                          clk_sys,
  input  logic                          init_n,
  input  logic                          dl_wr,
  input  logic [23:0]                   dl_addr,
  input  logic [7:0]                    dl_data,
  output logic                          dl_ready,
  output logic                          dl_overflow,
  input  logic                          line_start,
  input  logic [8:0]                    line_idx,
  output logic                          line_done,
  output logic                          line_err,
  input  logic [$clog2(LINE_WORDS)-1:0] rd_addr,
  output logic [15:0]                   rd_data,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [1:0]                    mem_ds,
  output logic [15:0]                   mem_d,
  input  logic                          mem_ack,
  input  logic [15:0]                   mem_q
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]                   stat_wr,
  output logic [31:0]                   stat_rd,
  output logic [15:0]                   stat_drop
`endif
);

  localparam int LW_W = $clog2(LINE_WORDS);
  localparam int FP_W = $clog2(WFIFO_DEPTH);
  localparam int ST_W = $clog2(STARVE_MAX + 1);
  localparam logic [FP_W:0]   FIFO_FULL = (FP_W + 1)'(WFIFO_DEPTH);
  localparam logic [ST_W-1:0] ST_MAX    = ST_W'(STARVE_MAX);
  localparam logic [LW_W-1:0] LAST_WORD = LW_W'(LINE_WORDS - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_GRANT    = 2'd1;
  localparam logic [1:0] S_WAIT_ACK = 2'd2;

  // Write FIFO storage and pointers
  logic [23:0]     fifo_addr_mem [WFIFO_DEPTH];
  logic [7:0]      fifo_data_mem [WFIFO_DEPTH];
  logic [FP_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [FP_W:0]   fcount_q, fcount_d;
  logic            overflow_q;

  // Ping-pong line buffer: bank select is the MSB of the index
  logic [15:0]     lbuf [2*LINE_WORDS];
  logic [15:0]     rd_data_q;

  // Arbiter / request registers
  logic [1:0]        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [1:0]        mem_ds_q, mem_ds_d;
  logic [15:0]       mem_d_q, mem_d_d;
  logic              op_gen_q, op_gen_d;
  logic [ST_W-1:0]   starve_q, starve_d;

  // Fetch tracking
  logic              act_q, act_d;
  logic [LW_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              gen_q, gen_d;
  logic              disp_q, disp_d;
  logic              line_done_q, line_done_d;
  logic              line_err_q, line_err_d;

  logic              full, empty, pop, push, drop, ack_in, rd_ack;
  logic [23:0]       head_addr;
  logic [7:0]        head_data;
  logic [ADDR_W-1:0] line_base;
  logic              unused_head_hi;

  assign full      = (fcount_q == FIFO_FULL);
  assign empty     = (fcount_q == '0);
  assign ack_in    = (state_q == S_WAIT_ACK) && mem_ack;
  assign pop       = ack_in && mem_we_q;
  // A full FIFO still accepts a byte in the cycle it pops one
  assign push      = dl_wr && (!full || pop);
  assign drop      = dl_wr && full && !pop;
  // Reads issued before a restart carry the old generation and are discarded
  assign rd_ack    = ack_in && !mem_we_q && act_q && (op_gen_q == gen_q);
  assign head_addr = fifo_addr_mem[rd_ptr_q];
  assign head_data = fifo_data_mem[rd_ptr_q];
  assign line_base = ADDR_W'({line_idx, {LW_W{1'b0}}});
  assign unused_head_hi = ^(head_addr >> (ADDR_W + 1));

  assign dl_ready    = !full;
  assign dl_overflow = overflow_q;
  assign line_done   = line_done_q;
  assign line_err    = line_err_q;
  assign rd_data     = rd_data_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_ds      = mem_ds_q;
  assign mem_d       = mem_d_q;

  // FIFO occupancy next-state
  always_comb begin
    fcount_d = fcount_q;
    if (push && !pop)      fcount_d = fcount_q + 1'b1;
    else if (pop && !push) fcount_d = fcount_q - 1'b1;
  end

  // Fetch progress: restart on line_start, advance and complete on read acks
  always_comb begin
    act_d       = act_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    gen_d       = gen_q;
    disp_d      = disp_q;
    line_done_d = 1'b0;
    line_err_d  = line_err_q;
    if (line_start) begin
      act_d  = 1'b1;
      cnt_d  = '0;
      base_d = line_base;
      gen_d  = ~gen_q;
      if (act_q) line_err_d = 1'b1;
    end else if (rd_ack) begin
      if (cnt_q == LAST_WORD) begin
        act_d       = 1'b0;
        disp_d      = ~disp_q;
        line_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Arbiter FSM: choose read or write in IDLE, raise request, wait for ack
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_ds_d   = mem_ds_q;
    mem_d_d    = mem_d_q;
    op_gen_d   = op_gen_q;
    starve_d   = act_q ? starve_q : '0;
    case (state_q)
      S_IDLE: begin
        if (act_q && (empty || starve_q < ST_MAX)) begin
          mem_we_d   = 1'b0;
          mem_addr_d = base_q + ADDR_W'(cnt_q);
          mem_ds_d   = 2'b11;
          op_gen_d   = gen_q;
          if (starve_q != ST_MAX) starve_d = starve_q + 1'b1;
          state_d    = S_GRANT;
        end else if (!empty) begin
          mem_we_d   = 1'b1;
          mem_addr_d = head_addr[ADDR_W:1];
          mem_ds_d   = {head_addr[0], ~head_addr[0]};
          mem_d_d    = {head_data, head_data};
          starve_d   = '0;
          state_d    = S_GRANT;
        end
      end
      S_GRANT: begin
        mem_req_d = 1'b1;
        state_d   = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk_sys or negedge init_n) begin
    if (!init_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fcount_q    <= '0;
      overflow_q  <= 1'b0;
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_ds_q    <= 2'b00;
      mem_d_q     <= 16'h0000;
      op_gen_q    <= 1'b0;
      starve_q    <= '0;
      act_q       <= 1'b0;
      cnt_q       <= '0;
      base_q      <= '0;
      gen_q       <= 1'b0;
      disp_q      <= 1'b0;
      line_done_q <= 1'b0;
      line_err_q  <= 1'b0;
      rd_data_q   <= 16'h0000;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      fcount_q    <= fcount_d;
      if (drop) overflow_q <= 1'b1;
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_ds_q    <= mem_ds_d;
      mem_d_q     <= mem_d_d;
      op_gen_q    <= op_gen_d;
      starve_q    <= starve_d;
      act_q       <= act_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      gen_q       <= gen_d;
      disp_q      <= disp_d;
      line_done_q <= line_done_d;
      line_err_q  <= line_err_d;
      rd_data_q   <= lbuf[{disp_q, rd_addr}];
    end
  end

  // FIFO storage write (no reset needed on data)
  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_addr_mem[wr_ptr_q] <= dl_addr;
      fifo_data_mem[wr_ptr_q] <= dl_data;
    end
  end

  // Line buffer fill: accepted read data goes into the non-displayed bank
  always_ff @(posedge clk_sys) begin
    if (rd_ack) lbuf[{~disp_q, cnt_q}] <= mem_q;
  end

`ifdef ARB_STATS_EN
  logic [31:0] stat_wr_q, stat_rd_q;
  logic [15:0] stat_drop_q;
  assign stat_wr   = stat_wr_q;
  assign stat_rd   = stat_rd_q;
  assign stat_drop = stat_drop_q;

  // Transaction counters; drop counter saturates
  always_ff @(posedge clk_sys or negedge init_n) begin
    if (!init_n) begin
      stat_wr_q   <= '0;
      stat_rd_q   <= '0;
      stat_drop_q <= '0;
    end else begin
      if (pop) stat_wr_q <= stat_wr_q + 1'b1;
      if (ack_in && !mem_we_q) stat_rd_q <= stat_rd_q + 1'b1;
      if (drop && stat_drop_q != 16'hFFFF) stat_drop_q <= stat_drop_q + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sdram_line_arb.sv
// Directed bench for sdram_line_arb: write FIFO, overflow, line fetch,
// starvation pattern, fetch restart and reset during an outstanding request.
module tb_sdram_line_arb;

  typedef struct {
    logic        we;
    logic [22:0] addr;
    logic [1:0]  ds;
    logic [15:0] d;
  } txn_t;

  logic        clk_sys = 1'b0;
  logic        init_n = 1'b0;
  logic        dl_wr = 1'b0;
  logic [23:0] dl_addr = '0;
  logic [7:0]  dl_data = '0;
  logic        dl_ready, dl_overflow;
  logic        line_start = 1'b0;
  logic [8:0]  line_idx = '0;
  logic        line_done, line_err;
  logic [8:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic        mem_req, mem_we;
  logic [22:0] mem_addr;
  logic [1:0]  mem_ds;
  logic [15:0] mem_d;
  logic        mem_ack;
  logic [15:0] mem_q = '0;
`ifdef ARB_STATS_EN
  logic [31:0] stat_wr, stat_rd;
  logic [15:0] stat_drop;
`endif

  always #5 clk_sys = ~clk_sys;

  sdram_line_arb dut (
    .clk_sys(clk_sys), .init_n(init_n),
    .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .dl_ready(dl_ready), .dl_overflow(dl_overflow),
    .line_start(line_start), .line_idx(line_idx),
    .line_done(line_done), .line_err(line_err),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_ds(mem_ds), .mem_d(mem_d), .mem_ack(mem_ack), .mem_q(mem_q)
`ifdef ARB_STATS_EN
    , .stat_wr(stat_wr), .stat_rd(stat_rd), .stat_drop(stat_drop)
`endif
  );

  int   n_cmp = 0;
  int   n_err = 0;
  txn_t log_q[$];
  int   done_cnt = 0;

  // SDRAM model: acks after ack_dly cycles unless held; mem_q = word index or address
  int   ack_dly = 3;
  bit   hold = 1'b1;
  bit   qmode = 1'b0;
  int   wcnt = 0;
  logic mem_ack_r = 1'b0;
  logic late_ack = 1'b0;
  assign mem_ack = mem_ack_r | late_ack;

  always @(posedge clk_sys) begin
    mem_ack_r <= 1'b0;
    if (mem_req && !mem_ack_r && !hold) begin
      if (wcnt >= ack_dly - 1) begin
        mem_ack_r <= 1'b1;
        mem_q     <= qmode ? mem_addr[15:0] : {7'd0, mem_addr[8:0]};
        log_q.push_back('{mem_we, mem_addr, mem_ds, mem_d});
        wcnt      <= 0;
        if (mem_we) $display("txn write addr=0x%0h ds=%b d=0x%04h", mem_addr, mem_ds, mem_d);
      end else begin
        wcnt <= wcnt + 1;
      end
    end else if (!mem_req) begin
      wcnt <= 0;
    end
  end

  always @(posedge clk_sys) begin
    if (line_done) begin
      done_cnt <= done_cnt + 1;
      $display("txn line_done #%0d", done_cnt + 1);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(input logic we, input logic [22:0] a,
                                     input logic [1:0] ds, input logic [15:0] d);
    return {22'd0, we, a, ds, d};
  endfunction

  function automatic logic [63:0] pk_t(input txn_t t);
    return pk(t.we, t.addr, t.ds, t.d);
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk_sys); #1; end
  endtask

  task automatic push_wr(input logic [23:0] a, input logic [7:0] d);
    dl_wr = 1'b1; dl_addr = a; dl_data = d;
    tick();
    dl_wr = 1'b0;
  endtask

  task automatic pulse_line(input logic [8:0] idx);
    line_start = 1'b1; line_idx = idx;
    tick();
    line_start = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    int c = 0;
    while (log_q.size() < n && c < budget) begin tick(); c++; end
    if (log_q.size() < n) chk(tag, log_q.size(), n);
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int c = 0;
    while (done_cnt < target && c < budget) begin tick(); c++; end
    if (done_cnt < target) chk(tag, done_cnt, target);
  endtask

  initial begin
    int seq_bad;
    int n_new;
    int d0;
    logic [63:0] pat;

    // Reset state
    tick(3);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_line_done", line_done, 1'b0);
    chk("rst_line_err", line_err, 1'b0);
    chk("rst_overflow", dl_overflow, 1'b0);
    chk("rst_rd_data", rd_data, 16'h0000);
    chk("rst_dl_ready", dl_ready, 1'b1);
    init_n = 1'b1;
    hold = 1'b0;
    ack_dly = 3;
    tick(2);

    // T1: four spaced byte writes
    log_q.delete();
    for (int i = 0; i < 4; i++) begin
      chk("t1_ready_before", dl_ready, 1'b1);
      push_wr(24'(i), 8'(8'h11 * (i + 1)));
      chk("t1_ready_after", dl_ready, 1'b1);
      wait_log(i + 1, 100, "t1_timeout");
      tick(2);
    end
    tick(5);
    chk("t1_count", log_q.size(), 4);
    if (log_q.size() >= 4) begin
      chk("t1_w0", pk_t(log_q[0]), pk(1'b1, 23'd0, 2'b01, 16'h1111));
      chk("t1_w1", pk_t(log_q[1]), pk(1'b1, 23'd0, 2'b10, 16'h2222));
      chk("t1_w2", pk_t(log_q[2]), pk(1'b1, 23'd1, 2'b01, 16'h3333));
      chk("t1_w3", pk_t(log_q[3]), pk(1'b1, 23'd1, 2'b10, 16'h4444));
    end

    // T2: five back-to-back writes with acks withheld
    hold = 1'b1;
    log_q.delete();
    for (int i = 0; i < 5; i++) begin
      push_wr(24'h20 + 24'(i), 8'hA0 + 8'(i));
      if (i == 2) chk("t2_ready_3rd", dl_ready, 1'b1);
      if (i == 3) chk("t2_ready_4th", dl_ready, 1'b0);
    end
    chk("t2_overflow", dl_overflow, 1'b1);
    hold = 1'b0;
    wait_log(4, 200, "t2_timeout");
    tick(20);
    chk("t2_count", log_q.size(), 4);
    if (log_q.size() >= 4) begin
      chk("t2_w0", pk_t(log_q[0]), pk(1'b1, 23'h10, 2'b01, 16'hA0A0));
      chk("t2_w1", pk_t(log_q[1]), pk(1'b1, 23'h10, 2'b10, 16'hA1A1));
      chk("t2_w2", pk_t(log_q[2]), pk(1'b1, 23'h11, 2'b01, 16'hA2A2));
      chk("t2_w3", pk_t(log_q[3]), pk(1'b1, 23'h11, 2'b10, 16'hA3A3));
    end
    chk("t2_ready_end", dl_ready, 1'b1);
    chk("t2_overflow_sticky", dl_overflow, 1'b1);

    // T3: fetch line 3 with no writes
    ack_dly = 1;
    qmode = 1'b0;
    log_q.delete();
    pulse_line(9'd3);
    wait_done(1, 8000, "t3_timeout");
    tick(10);
    chk("t3_count", log_q.size(), 512);
    seq_bad = 0;
    foreach (log_q[i]) if (log_q[i].we || log_q[i].addr != 23'(1536 + i)) seq_bad++;
    chk("t3_seq_errors", seq_bad, 0);
    if (log_q.size() > 0) begin
      chk("t3_first_addr", log_q[0].addr, 23'd1536);
      chk("t3_last_addr", log_q[log_q.size()-1].addr, 23'd2047);
    end
    chk("t3_done_count", done_cnt, 1);
    chk("t3_line_err", line_err, 1'b0);
    rd_addr = 9'd5;
    tick();
    chk("t3_rd_5", rd_data, 16'h0005);
    rd_addr = 9'd511;
    tick();
    chk("t3_rd_511", rd_data, 16'h01FF);

    // T4: fetch of line 5 with two writes queued just after it starts
    log_q.delete();
    pulse_line(9'd5);
    dl_wr = 1'b1; dl_addr = 24'h40; dl_data = 8'h55;
    tick();
    dl_addr = 24'h41; dl_data = 8'h66;
    tick();
    dl_wr = 1'b0;
    wait_log(20, 400, "t4_timeout");
    pat = '0;
    for (int i = 0; i < 20 && i < log_q.size(); i++) pat[i] = log_q[i].we;
    chk("t4_grant_pattern", pat, 64'h20100);
    if (log_q.size() >= 20) begin
      chk("t4_write0", pk_t(log_q[8]), pk(1'b1, 23'h20, 2'b01, 16'h5555));
      chk("t4_write1", pk_t(log_q[17]), pk(1'b1, 23'h20, 2'b10, 16'h6666));
      chk("t4_read_after_w", log_q[9].addr, 23'd2568);
    end
    wait_done(2, 8000, "t4_done_timeout");
    tick(5);

    // T5: restart at word 100 of line 10 with line 11
    qmode = 1'b1;
    log_q.delete();
    d0 = done_cnt;
    pulse_line(9'd10);
    wait_log(100, 2000, "t5_timeout");
    pulse_line(9'd11);
    chk("t5_line_err", line_err, 1'b1);
    rd_addr = 9'd7;
    tick();
    chk("t5_disp_unchanged", rd_data, 16'h0007);
    chk("t5_no_done_yet", done_cnt, d0);
    wait_done(d0 + 1, 8000, "t5_done_timeout");
    tick(20);
    chk("t5_done_once", done_cnt, d0 + 1);
    n_new = 0;
    foreach (log_q[i]) if (log_q[i].addr >= 23'd5632) n_new++;
    chk("t5_new_reads", n_new, 512);
    if (log_q.size() > 0) chk("t5_last_addr", log_q[log_q.size()-1].addr, 23'd6143);
    rd_addr = 9'd0;
    tick();
    chk("t5_rd_0", rd_data, 16'h1600);
    rd_addr = 9'd7;
    tick();
    chk("t5_rd_7", rd_data, 16'h1607);

    // T6: reset while a write is outstanding; late ack must be ignored
    hold = 1'b1;
    log_q.delete();
    push_wr(24'h30, 8'h77);
    for (int c = 0; c < 20 && !mem_req; c++) tick();
    chk("t6_req_up", mem_req, 1'b1);
    tick(2);
    init_n = 1'b0;
    #1;
    chk("t6_rst_req", mem_req, 1'b0);
    chk("t6_rst_ready", dl_ready, 1'b1);
    chk("t6_rst_err", line_err, 1'b0);
    chk("t6_rst_ovf", dl_overflow, 1'b0);
    chk("t6_rst_rd_data", rd_data, 16'h0000);
`ifdef ARB_STATS_EN
    chk("t6_stat_wr", stat_wr, 32'd0);
    chk("t6_stat_rd", stat_rd, 32'd0);
    chk("t6_stat_drop", stat_drop, 16'd0);
`endif
    tick();
    init_n = 1'b1;
    tick();
    late_ack = 1'b1;
    tick();
    late_ack = 1'b0;
    tick(5);
    chk("t6_idle_after_late_ack", mem_req, 1'b0);
    chk("t6_ready_after_late_ack", dl_ready, 1'b1);
    hold = 1'b0;
    push_wr(24'h31, 8'h88);
    wait_log(1, 100, "t6_timeout");
    tick(20);
    chk("t6_count", log_q.size(), 1);
    if (log_q.size() >= 1) chk("t6_w0", pk_t(log_q[0]), pk(1'b1, 23'h18, 2'b10, 16'h8888));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
